// File: rtl/regbank_pkg.sv
// Shared types and constants for the register bank arbiter slice.
// Holds the FSM state encoding, requester port ids and the ID register address.
package regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int ID_ADDR = 0;

    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

endpackage

// File: rtl/regbank_arbiter_rr_arb2.sv
// Two-way round-robin picker.
// The priority pointer moves to the losing side whenever a grant is taken.
module rr_arb2
    import regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_idx,
    output logic       valid
);

    logic prio;

    // A lone requester wins outright; a tie goes to the side holding priority.
    always_comb begin
        valid     = |req;
        grant_idx = PORT_A;
        if (&req) begin
            grant_idx = prio;
        end else if (req[1]) begin
            grant_idx = PORT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= PORT_A;
        end else if (advance && valid) begin
            prio <= ~grant_idx;
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Register bank shared between the SPI command engine (A) and the PWM engine (B).
// One fixed 3-cycle transaction at a time; bank contents are also exported flat.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int                 NREGS    = 4,
    parameter int                 ADDR_W   = 7,
    parameter logic [NREGS*8-1:0] RST_VALS = 32'h03020196,
    parameter bit                 ID_RO    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [ADDR_W-1:0]  a_addr,
    input  logic [7:0]         a_wdata,
    output logic               a_gnt,
    output logic               a_rvalid,
    output logic [7:0]         a_rdata,
    output logic               a_err,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [ADDR_W-1:0]  b_addr,
    input  logic [7:0]         b_wdata,
    output logic               b_gnt,
    output logic               b_rvalid,
    output logic [7:0]         b_rdata,
    output logic               b_err,
    output logic [NREGS*8-1:0] regs_flat,
    output logic               busy
);

    localparam int IDX_W = (NREGS > 2) ? $clog2(NREGS) : 1;

    state_t             state;
    state_t             next_state;
    logic               advance;
    logic               arb_idx;
    logic               arb_valid;
    logic               win;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [7:0]         lat_wdata;
    logic [7:0]         bank [NREGS];
    logic [7:0]         rdata_q;
    logic               err_q;
    logic               addr_ok;
    logic               ro_hit;
    logic               wr_ok;
    logic [IDX_W-1:0]   idx;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({b_req, a_req}),
        .advance   (advance),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    next_state = ACCESS;
                    advance    = 1'b1;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Winner's request is captured so its inputs may change once granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            win       <= PORT_A;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (advance) begin
            win       <= arb_idx;
            lat_we    <= (arb_idx == PORT_B) ? b_we    : a_we;
            lat_addr  <= (arb_idx == PORT_B) ? b_addr  : a_addr;
            lat_wdata <= (arb_idx == PORT_B) ? b_wdata : a_wdata;
        end
    end

    assign addr_ok = (lat_addr < ADDR_W'(NREGS));
    assign ro_hit  = ID_RO && (lat_addr == ADDR_W'(ID_ADDR));
    assign wr_ok   = lat_we && addr_ok && !ro_hit;
    assign idx     = lat_addr[IDX_W-1:0];

    // Reset wins over the ACCESS commit, so an interrupted write never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                bank[i] <= RST_VALS[8*i +: 8];
            end
            rdata_q <= 8'h00;
            err_q   <= ERR_NONE;
        end else if (state == ACCESS) begin
            if (wr_ok) begin
                bank[idx] <= lat_wdata;
            end
            rdata_q <= (!lat_we && addr_ok) ? bank[idx] : 8'h00;
            err_q   <= (!addr_ok || (lat_we && ro_hit)) ? ERR_ACCESS : ERR_NONE;
        end
    end

    assign a_gnt    = (state == ACCESS) && (win == PORT_A);
    assign b_gnt    = (state == ACCESS) && (win == PORT_B);
    assign a_rvalid = (state == RESP) && (win == PORT_A);
    assign b_rvalid = (state == RESP) && (win == PORT_B);
    assign a_rdata  = a_rvalid ? rdata_q : 8'h00;
    assign b_rdata  = b_rvalid ? rdata_q : 8'h00;
    assign a_err    = a_rvalid && err_q;
    assign b_err    = b_rvalid && err_q;
    assign busy     = (state != IDLE);

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = bank[g];
    end

endmodule
